// File: rtl/pwm_duty_controller.sv
// Button-driven PWM duty controller: debounced up/down buttons step a target duty,
// which is applied to the PWM generator only at period boundaries.

module pwm_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FILTER, PRESSED, HOLD, RELEASE} state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          sync_a, sync_x;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_x <= 1'b0;
         state  <= IDLE;
         cnt    <= '0;
      end else begin
         sync_a <= btn;
         sync_x <= sync_a;
         state  <= state_next;
         cnt    <= cnt_next;
      end
   end

   // Press and release must each hold steady for the full filter window;
   // a glitch in either phase drops back to the previous stable state.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      press      = 1'b0;
      case (state)
         IDLE: begin
            if (sync_x) begin
               state_next = FILTER;
               cnt_next   = '0;
            end
         end
         FILTER: begin
            if (!sync_x)
               state_next = IDLE;
            else if (cnt == CNT_LAST)
               state_next = PRESSED;
            else
               cnt_next = cnt + 1'b1;
         end
         PRESSED: begin
            press      = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (!sync_x) begin
               state_next = RELEASE;
               cnt_next   = '0;
            end
         end
         RELEASE: begin
            if (sync_x)
               state_next = HOLD;
            else if (cnt == CNT_LAST)
               state_next = IDLE;
            else
               cnt_next = cnt + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

module pwm_duty_controller #(
   parameter int PWM_PERIOD      = 100,
   parameter int STEP            = 10,
   parameter int DUTY_RESET      = 50,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DW              = $clog2(PWM_PERIOD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   output logic          pwm_out,
   output logic [DW-1:0] duty_active,
   output logic [DW-1:0] duty_target,
   output logic          at_max,
   output logic          at_min
);

   localparam logic [DW:0]   PERIOD_W = (DW+1)'(PWM_PERIOD);
   localparam logic [DW:0]   STEP_W   = (DW+1)'(STEP);
   localparam logic [DW-1:0] PERIOD_D = DW'(PWM_PERIOD);
   localparam logic [DW-1:0] RESET_D  = DW'(DUTY_RESET);
   localparam logic [DW-1:0] CNT_LAST = DW'(PWM_PERIOD - 1);

   logic          up_pulse, down_pulse;
   logic [DW-1:0] pwm_cnt;
   logic [DW:0]   sum, diff;
   logic [DW-1:0] target_next;

   pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up),
      .press (up_pulse)
   );

   pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_down),
      .press (down_pulse)
   );

   // One extra bit keeps the saturating add/subtract free of wrap-around;
   // diff's top bit is the borrow out of the subtraction.
   always_comb begin
      sum         = {1'b0, duty_target} + STEP_W;
      diff        = {1'b0, duty_target} - STEP_W;
      target_next = duty_target;
      if (up_pulse && !down_pulse)
         target_next = (sum > PERIOD_W) ? PERIOD_D : sum[DW-1:0];
      else if (down_pulse && !up_pulse)
         target_next = diff[DW] ? '0 : diff[DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt     <= '0;
         pwm_out     <= 1'b0;
         duty_active <= RESET_D;
         duty_target <= RESET_D;
      end else begin
         duty_target <= target_next;
         pwm_out     <= (pwm_cnt < duty_active);
         if (pwm_cnt == CNT_LAST) begin
            pwm_cnt     <= '0;
            duty_active <= duty_target;
         end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
      end
   end

   assign at_max = (duty_target == PERIOD_D);
   assign at_min = (duty_target == '0);

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed bench for pwm_duty_controller with a short period and filter window
// so every duty, debounce and saturation case fits in a few hundred cycles.

module tb_pwm_duty_controller;

   localparam int PERIOD = 10;
   localparam int STEP   = 2;
   localparam int DRST   = 4;
   localparam int DEB    = 4;
   localparam int DW     = $clog2(PERIOD + 1);

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          btn_up   = 1'b0;
   logic          btn_down = 1'b0;
   logic          pwm_out;
   logic [DW-1:0] duty_active;
   logic [DW-1:0] duty_target;
   logic          at_max;
   logic          at_min;

   int         n_compared   = 0;
   int         n_mismatched = 0;
   int         n_high;
   logic [9:0] pattern;

   int up_exp[4]   = '{6, 8, 10, 10};
   int down_exp[6] = '{8, 6, 4, 2, 0, 0};

   always #5 clk = ~clk;

   pwm_duty_controller #(
      .PWM_PERIOD      (PERIOD),
      .STEP            (STEP),
      .DUTY_RESET      (DRST),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .pwm_out     (pwm_out),
      .duty_active (duty_active),
      .duty_target (duty_target),
      .at_max      (at_max),
      .at_min      (at_min)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input logic up, input logic down, input int hold, input int rel);
      btn_up   = up;
      btn_down = down;
      tick(hold);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(rel);
   endtask

   task automatic countHigh(output int n);
      n = 0;
      repeat (PERIOD) begin
         tick(1);
         if (pwm_out) n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      tick(3);
      checkOutput("reset_target", duty_target, 4);
      checkOutput("reset_active", duty_active, 4);
      checkOutput("reset_at_max", at_max, 0);
      checkOutput("reset_at_min", at_min, 0);
      checkOutput("reset_pwm", pwm_out, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pattern[i] = pwm_out;
      end
      checkOutput("reset_pwm_pattern", pattern, 10'b0000001111);
      countHigh(n_high);
      checkOutput("reset_high_count", n_high, 4);

      $display("[TB] bounce rejection");
      doReset();
      btn_up = 1'b1; tick(3);
      btn_up = 1'b0; tick(1);
      btn_up = 1'b1; tick(3);
      btn_up = 1'b0; tick(20);
      checkOutput("bounce_target", duty_target, 4);

      $display("[TB] single press");
      doReset();
      btn_up = 1'b1;
      tick(7);
      checkOutput("press_before", duty_target, 4);
      tick(1);
      checkOutput("press_target", duty_target, 6);
      checkOutput("press_active_hold", duty_active, 4);
      tick(1);
      checkOutput("active_before_boundary", duty_active, 4);
      tick(1);
      checkOutput("active_after_boundary", duty_active, 6);
      countHigh(n_high);
      checkOutput("press_high_count", n_high, 6);
      tick(10);
      btn_up = 1'b0;
      tick(30);
      checkOutput("press_once", duty_target, 6);

      $display("[TB] saturation");
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 10, 10);
         checkOutput("sat_up_target", duty_target, up_exp[i]);
      end
      checkOutput("sat_at_max", at_max, 1);
      tick(20);
      checkOutput("sat_active_max", duty_active, 10);
      countHigh(n_high);
      checkOutput("sat_high_full", n_high, 10);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, 10, 10);
         checkOutput("sat_down_target", duty_target, down_exp[i]);
      end
      checkOutput("sat_at_min", at_min, 1);
      checkOutput("sat_at_max_clear", at_max, 0);
      tick(20);
      checkOutput("sat_active_min", duty_active, 0);
      countHigh(n_high);
      checkOutput("sat_high_none", n_high, 0);

      $display("[TB] simultaneous presses");
      doReset();
      applyStimulus(1'b1, 1'b1, 20, 20);
      checkOutput("simul_target", duty_target, 4);
      btn_up = 1'b1;
      tick(2);
      btn_down = 1'b1;
      tick(6);
      checkOutput("stagger_up", duty_target, 6);
      tick(2);
      checkOutput("stagger_down", duty_target, 4);
      tick(10);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(20);
      checkOutput("stagger_final", duty_target, 4);

      $display("[TB] reset mid-operation");
      doReset();
      tick(2);
      btn_up = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(1);
      checkOutput("midrst_pwm", pwm_out, 0);
      checkOutput("midrst_target", duty_target, 4);
      checkOutput("midrst_active", duty_active, 4);
      rst = 1'b0;
      pattern = '0;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         pattern[i] = pwm_out;
      end
      checkOutput("midrst_refilter", duty_target, 4);
      tick(1);
      pattern[7] = pwm_out;
      checkOutput("midrst_press", duty_target, 6);
      checkOutput("midrst_pwm_pattern", pattern, 10'b0000001111);
      btn_up = 1'b0;
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
